// File: rtl/instr_fetch.sv
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : PC owner and IF/ID register with valid/ready, stall and redirect
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
   parameter int unsigned          PC_WIDTH    = 8,
   parameter int unsigned          INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
   input  logic                   sysclk,
   input  logic                   rst,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic [PC_WIDTH-1:0]    out_pc_plus4,
   output logic                   misalign_err,
   output logic [15:0]            fetch_count
);

   localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(4);

   logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic                   misalign_q, misalign_d;
   logic [15:0]            count_q, count_d;
   logic                   xfer;

   assign xfer = valid_q && out_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      misalign_d = misalign_q;
      count_d    = count_q + {15'd0, xfer};
      // Redirect flushes the output register even when decode takes it this cycle.
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
         valid_d    = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end else if (!valid_q || out_ready) begin
         instr_d    = imem_instr;
         pc_d       = fetch_pc_q;
         valid_d    = 1'b1;
         fetch_pc_d = fetch_pc_q + C_PC_STEP;
      end
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
         count_q    <= count_d;
      end
   end

   assign imem_addr    = fetch_pc_q;
   assign out_valid    = valid_q;
   assign out_instr    = instr_q;
   assign out_pc       = pc_q;
   assign out_pc_plus4 = pc_q + C_PC_STEP;
   assign misalign_err = misalign_q;
   assign fetch_count  = count_q;

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RISC-V simple datapath. Owns the program counter, drives the byte address into `instr_mem`, and registers the returned 32-bit instruction into an IF/ID output register with a valid/ready handshake to decode. Supports stalls from downstream and redirects (branch/jump) that flush the in-flight fetch.

## Interface
- `PC_WIDTH`, 8, byte-address width; matches `instr_mem` address port.
- `INSTR_WIDTH`, 32, instruction width.
- `RESET_PC`, 8'h00, PC value loaded on reset.

Ports:
- `sysclk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  PC_WIDTH  address to `instr_mem`; equals `fetch_pc` combinationally.
- `imem_instr`  in  INSTR_WIDTH  instruction from `instr_mem` for `imem_addr`, valid in the same cycle.
- `redirect_valid`  in  1  load new PC, flush output register.
- `redirect_pc`  in  PC_WIDTH  redirect target.
- `out_valid`  out  1  IF/ID register holds a valid instruction.
- `out_ready`  in  1  decode accepts this cycle.
- `out_instr`  out  INSTR_WIDTH  fetched instruction.
- `out_pc`  out  PC_WIDTH  address of `out_instr`.
- `out_pc_plus4`  out  PC_WIDTH  `out_pc + 4`, mod 2^PC_WIDTH, combinational.
- `misalign_err`  out  1  sticky; set when a redirect target has nonzero bits [1:0].
- `fetch_count`  out  16  number of completed handshakes, wraps at 16'hFFFF -> 0.

## Operation
- State: `fetch_pc`, output register (`out_valid`, `out_instr`, `out_pc`), `misalign_err`, `fetch_count`.
- Transfer = `out_valid && out_ready`.
- Priority each rising edge, highest first:
  - `rst`: `fetch_pc`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `misalign_err`=0, `fetch_count`=0.
  - `redirect_valid`: `fetch_pc` = `redirect_pc` with bits [1:0] forced to 0; `out_valid`=0 (flush, even if a transfer occurs this cycle); `misalign_err` set if `redirect_pc[1:0]!=0`. `fetch_count` still increments if a transfer occurs this cycle.
  - Load (`!out_valid || out_ready`): `out_instr`=`imem_instr`, `out_pc`=`fetch_pc`, `out_valid`=1, `fetch_pc`=`fetch_pc`+4 mod 2^PC_WIDTH.
  - Stall (`out_valid && !out_ready`): all state held; `imem_addr` stable.
- `fetch_count` += 1 on every transfer not coincident with `rst`.
- PC arithmetic is PC_WIDTH-bit unsigned; 8'hFC + 4 = 8'h00, no flag.
- `misalign_err` cleared only by `rst`.
- `out_instr`/`out_pc` contents are don't-care while `out_valid`=0 but never change while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_pc`=0, `misalign_err`=0, `fetch_count`=0, `imem_addr`=RESET_PC.
- First valid: reset deasserted before edge E -> `out_valid`=1 with `out_pc`=RESET_PC after edge E.
- Steady state with `out_ready`=1: one instruction per cycle, PCs 0,4,8,...
- Redirect sampled at edge N: after N `out_valid`=0, `imem_addr`=target; after N+1 `out_valid`=1, `out_pc`=target. Exactly one bubble.
- Redirect during stall: flushes the held instruction; no transfer of it unless `out_ready`=1 that same cycle.
- Reset asserted mid-stream overrides redirect and stall in the same cycle.

## Test plan
- Reset then `out_ready`=1 for 4 cycles, memory word at addr k = 32'hA000_0000|k -> `out_pc` 00,04,08,0C, `out_instr` A000_0000, A000_0004, ..., `fetch_count`=4, `out_pc_plus4` always `out_pc`+4.
- Hold `out_ready`=0 for 3 cycles with `out_pc`=08 -> `out_pc`, `out_instr`, `imem_addr`=0C unchanged; release -> next `out_pc`=0C, `fetch_count` increments once per transfer only.
- Redirect to 8'h40 at cycle with `out_pc`=04 -> next cycle `out_valid`=0, following cycle `out_pc`=40, then 44; `misalign_err`=0.
- Redirect to 8'h42 -> `out_pc`=40 after bubble, `misalign_err`=1 and remains 1 until `rst`.
- Redirect to 8'hF8, `out_ready`=1 -> `out_pc` F8, FC, 00, 04; `out_pc_plus4`=00 when `out_pc`=FC.
- Assert `rst` together with `redirect_valid` (target 8'h40) mid-stream -> next cycle `out_valid`=0, `imem_addr`=00, `fetch_count`=0, `misalign_err`=0.
